// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD constants and controller state encoding
package bcd_pkg;
  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_MAX = 9;
  localparam int BCD_CORR = 6;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: combinational single-digit decimal adder stage
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       c,
  output logic [3:0] d,
  output logic       co
);
  logic [4:0] z;
  // binary sum, then +6 correction whenever it exceeds a decimal digit
  always_comb begin
    z = {1'b0, x} + {1'b0, y} + {4'b0, c};
    co = z > 5'(BCD_MAX);
    d = co ? 4'(z + 5'(BCD_CORR)) : z[3:0];
  end
endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl: digit-serial packed-BCD adder sequencer; define BCD_CHECK_EN for invalid-digit flag
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
  input  logic                          cin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] sum,
  output logic                          cout,
  output logic                          err
);
  localparam int W = BCD_DIGIT_W * DIGITS;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [W-1:0] a_q, b_q;
  logic carry, accept, last, co;
  logic [3:0] x, y, d;
  assign x = a_q[idx*BCD_DIGIT_W +: BCD_DIGIT_W];
  assign y = b_q[idx*BCD_DIGIT_W +: BCD_DIGIT_W];
  assign last = idx == IW'(DIGITS - 1);
  assign accept = start && state != RUN;
  assign busy = state == RUN;
  assign done = state == DONE;
  bcd_digit_add u_stage (.x(x), .y(y), .c(carry), .d(d), .co(co));
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state: start is only honoured outside RUN, so DONE may chain straight into RUN
  always_comb begin
    state_nx = state;
    if (state == RUN) state_nx = last ? DONE : RUN;
    else state_nx = accept ? RUN : IDLE;
  end
  // operand latch at accept, then one digit per cycle through the shared stage
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      carry <= 1'b0;
      idx <= '0;
      sum <= '0;
      cout <= 1'b0;
    end else if (accept) begin
      a_q <= a;
      b_q <= b;
      carry <= cin;
      idx <= '0;
      sum <= '0;
      cout <= 1'b0;
    end else if (state == RUN) begin
      sum[idx*BCD_DIGIT_W +: BCD_DIGIT_W] <= d;
      carry <= co;
      idx <= idx + 1'b1;
      if (last) cout <= co;
    end
`ifdef BCD_CHECK_EN
  // sticky invalid-digit flag over the current operation, cleared at accept
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err <= 1'b0;
    else if (accept) err <= 1'b0;
    else if (state == RUN && (x > 4'(BCD_MAX) || y > 4'(BCD_MAX))) err <= 1'b1;
`else
  assign err = 1'b0;
`endif
endmodule
